card_deck: RTL and testbench
============================

Name: card_deck

Overview:
- Card source feeding the ten-thirty game controller. It replaces the simple LUT dealer on the `pip` / `number` interface.
- Holds a real 52-card deck (4 suits × ranks 1..13). It deals without replacement, so at most four of any rank appear per shuffle.
- Shuffles with a Fisher-Yates pass driven by a free-running LFSR.
- Reports remaining cards and busy status so the controller can gate dealing.

Parameters:
- SEED, 16'hACE1: LFSR reset value. Must be non-zero.
- SHUFFLE_EN, 1: 1 runs the shuffle pass. 0 skips it, leaving the deck ordered 1..13 ×4 (bench mode).

Ports:
- clk  in  1  controller clock (the divided game clock in the top level)
- rst_n  in  1  asynchronous, active-low reset
- pip  in  1  deal request. Each cycle sampled high in READY deals one card.
- reshuffle  in  1  one-cycle request to rebuild and reshuffle the deck
- number  out  4  rank 1..13, valid for exactly one cycle. 0 = no card this cycle.
- busy  out  1  high while INIT or SHUFFLE
- cards_left  out  6  cards remaining, 0..52

Behaviour:

Reset:
- rst_n low: number=0, busy=1, cards_left=0, state=INIT, fill index=0, LFSR=SEED.
- Asserting rst_n mid-operation aborts immediately. The deck contents are then don't-care until INIT rewrites them.

LFSR:
- 16-bit Galois, taps x^16+x^14+x^13+x^11.
- Advances every cycle in every state, never reset except by rst_n.

State INIT:
- Writes deck[idx] = rank, one entry per cycle for idx 0..51.
- rank starts at 1 and wraps 13→1.
- After idx 51: go to SHUFFLE with i=51. If SHUFFLE_EN=0, go directly to READY.
- INIT takes exactly 52 cycles.

State SHUFFLE:
- Each cycle: j = lfsr[5:0].
- If j ≤ i: swap deck[i] and deck[j] in the same cycle, then i--.
- Otherwise retry next cycle (rejection sampling; no modulo hardware).
- When i reaches 0: go to READY, set cards_left=52.

State READY:
- Priority order:
  1. reshuffle=1 → INIT next cycle; number=0; any pip that cycle is dropped.
  2. pip=1 and cards_left>0 → number <= deck[52−cards_left] on this edge, cards_left--. Latency is 1 cycle from the sampling edge.
  3. Otherwise number <= 0.
- A held pip deals one card per cycle. A two-cycle pip produces two consecutive cards.
- After the last card is dealt (cards_left 1→0): go to INIT on the following edge automatically. No external request is needed.

Outside READY:
- pip and reshuffle are ignored.
- number is held at 0.
- cards_left reads 0.

Outputs:
- busy = (state != READY), registered.
- number is never non-zero for more than one consecutive cycle per dealt card. Consecutive deals produce consecutive non-zero cycles.

Storage:
- Deck is 52×4-bit registers; no memory macro.
- Read index is 52−cards_left, 6 bits wide. No wrap: the index range is 0..51.

Decomposition:
- Shared package `tenthirty_pkg`:
  - DECK_SIZE=52, RANK_MAX=13
  - LFSR tap mask 16'hB400
  - state enum {INIT, SHUFFLE, READY}
  - the rank encoding: 11..13 are the half-point cards, 0 means "no card"
- One natural sub-module: `card_lfsr` (16-bit Galois LFSR; parameter SEED; ports clk, rst_n, q[15:0]).

Test Plan:
1. SHUFFLE_EN=0, release rst_n → busy=1 for 52 cycles, then busy=0, cards_left=52, number=0 throughout.
2. SHUFFLE_EN=0, 13 single-cycle pip pulses spaced 3 cycles apart → number=1..13, each one cycle after its pulse; cards_left=39; number=0 otherwise.
3. SHUFFLE_EN=0, pip held 2 cycles after a reset → number=1 then 2 on consecutive cycles, then 0; cards_left=50.
4. Deal all 52 cards; pip stays asserted → last number=13, busy=1 next cycle, number=0 for all pips during the 52-cycle INIT; afterwards cards_left=52.
5. SHUFFLE_EN=1, default SEED, deal 52 → each rank 1..13 appears exactly 4 times. Order is not 1..13 ×4. Two identical resets with identical timing give identical sequences.
6. In READY, reshuffle and pip high on the same cycle → number=0, busy=1 next cycle. Then pull rst_n low mid-SHUFFLE → number=0, busy=1, cards_left=0 immediately, and INIT restarts.

Source files
------------

// File: rtl/tenthirty_pkg.sv
// Shared definitions for the ten-thirty card path: deck geometry, rank encoding,
// LFSR taps and the dealer state encoding.
package tenthirty_pkg;

   localparam int unsigned DECK_SIZE = 52;
   localparam int unsigned RANK_MAX  = 13;

   // Ranks 11..13 are the half-point cards; 0 means "no card this cycle".
   localparam logic [3:0] RANK_NONE  = 4'd0;
   localparam logic [3:0] RANK_FIRST = 4'd1;

   // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      SHUFFLE = 2'd1,
      READY   = 2'd2
   } deck_state_e;

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR; only rst_n reloads the seed.
module card_lfsr
   import tenthirty_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_step(lfsr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/card_deck.sv
// 52-card dealer: fills an ordered deck, Fisher-Yates shuffles it with rejection
// sampling on the LFSR, then deals one card per sampled pip without replacement.
module card_deck
   import tenthirty_pkg::*;
#(
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter bit          SHUFFLE_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pip,
   input  logic       reshuffle,
   output logic [3:0] number,
   output logic       busy,
   output logic [5:0] cards_left
);

   deck_state_e state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [3:0]  rank_q, rank_d;
   logic [3:0]  number_q, number_d;
   logic        busy_q, busy_d;
   logic [5:0]  cards_left_q, cards_left_d;
   logic [3:0]  deck_q [DECK_SIZE];
   logic [3:0]  deck_d [DECK_SIZE];

   logic [15:0] lfsr;
   logic [5:0]  j;
   logic [5:0]  deal_idx;
   logic        unused_lfsr;

   card_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   assign j           = lfsr[5:0];
   assign unused_lfsr = ^lfsr[15:6];
   assign deal_idx    = 6'(DECK_SIZE) - cards_left_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rank_d       = rank_q;
      number_d     = RANK_NONE;
      cards_left_d = cards_left_q;
      deck_d       = deck_q;

      unique case (state_q)
         INIT: begin
            deck_d[idx_q] = rank_q;
            rank_d = (rank_q == 4'(RANK_MAX)) ? RANK_FIRST : rank_q + 4'd1;
            if (idx_q == 6'(DECK_SIZE - 1)) begin
               if (SHUFFLE_EN) begin
                  // idx doubles as the Fisher-Yates index i, already at 51
                  state_d = SHUFFLE;
               end else begin
                  state_d      = READY;
                  cards_left_d = 6'(DECK_SIZE);
               end
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end

         SHUFFLE: begin
            // Out-of-range draws are retried next cycle instead of reduced modulo i+1.
            if (j <= idx_q) begin
               deck_d[idx_q] = deck_q[j];
               deck_d[j]     = deck_q[idx_q];
               idx_d         = idx_q - 6'd1;
               if (idx_q == 6'd1) begin
                  state_d      = READY;
                  cards_left_d = 6'(DECK_SIZE);
               end
            end
         end

         READY: begin
            if (reshuffle || (cards_left_q == 6'd0)) begin
               state_d      = INIT;
               idx_d        = 6'd0;
               rank_d       = RANK_FIRST;
               cards_left_d = 6'd0;
            end else if (pip) begin
               number_d     = deck_q[deal_idx];
               cards_left_d = cards_left_q - 6'd1;
            end
         end

         default: begin
            state_d      = INIT;
            idx_d        = 6'd0;
            rank_d       = RANK_FIRST;
            cards_left_d = 6'd0;
         end
      endcase

      busy_d = (state_d != READY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= INIT;
         idx_q        <= 6'd0;
         rank_q       <= RANK_FIRST;
         number_q     <= RANK_NONE;
         busy_q       <= 1'b1;
         cards_left_q <= 6'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rank_q       <= rank_d;
         number_q     <= number_d;
         busy_q       <= busy_d;
         cards_left_q <= cards_left_d;
      end
   end

   // Deck contents are rewritten by INIT after every reset, so no reset here.
   always_ff @(posedge clk) begin
      deck_q <= deck_d;
   end

   assign number     = number_q;
   assign busy       = busy_q;
   assign cards_left = cards_left_q;

endmodule

// File: tb/tb_card_deck.sv
// Directed bench for card_deck: an ordered-deck instance and a shuffling instance.
module tb_card_deck;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, pip0, resh0, busy0;
   logic [3:0] num0;
   logic [5:0] left0;
   logic       rst1_n, pip1, resh1, busy1;
   logic [3:0] num1;
   logic [5:0] left1;

   int errors = 0;
   int checks = 0;
   int ready_cycles = 0;
   logic [3:0] seq1 [52];
   logic [3:0] seq2 [52];

   card_deck #(
      .SEED       (16'hACE1),
      .SHUFFLE_EN (1'b0)
   ) u_dut0 (
      .clk        (clk),
      .rst_n      (rst0_n),
      .pip        (pip0),
      .reshuffle  (resh0),
      .number     (num0),
      .busy       (busy0),
      .cards_left (left0)
   );

   card_deck #(
      .SEED       (16'hACE1),
      .SHUFFLE_EN (1'b1)
   ) u_dut1 (
      .clk        (clk),
      .rst_n      (rst1_n),
      .pip        (pip1),
      .reshuffle  (resh1),
      .number     (num1),
      .busy       (busy1),
      .cards_left (left1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset0();
      rst0_n = 1'b0;
      pip0   = 1'b0;
      resh0  = 1'b0;
      tick();
      tick();
      rst0_n = 1'b1;
   endtask

   task automatic wait_ready0();
      int n = 0;
      while (busy0 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL ready0_timeout: busy=%0b after %0d cycles, required 0", busy0, n);
      end
   endtask

   // Returns the number of cycles spent busy after releasing reset on dut1.
   task automatic reset1_and_wait(output int n);
      rst1_n = 1'b0;
      pip1   = 1'b0;
      resh1  = 1'b0;
      tick();
      tick();
      rst1_n = 1'b1;
      n = 0;
      while (busy1 && n < 5000) begin
         tick();
         n++;
      end
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL ready1_timeout: busy=%0b after %0d cycles, required 0", busy1, n);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      rst0_n = 1'b0;
      tick();
      checks++;
      if (num0 !== 4'd0 || busy0 !== 1'b1 || left0 !== 6'd0) begin
         errors++;
         $display("FAIL reset0_values: number=%0d busy=%0b left=%0d, required 0 1 0",
                  num0, busy0, left0);
      end
      checks++;
      if (num1 !== 4'd0 || busy1 !== 1'b1 || left1 !== 6'd0) begin
         errors++;
         $display("FAIL reset1_values: number=%0d busy=%0b left=%0d, required 0 1 0",
                  num1, busy1, left1);
      end
      rst0_n = 1'b1;
      checks++;
      if (busy0 !== 1'b1) begin
         errors++;
         $display("FAIL init_busy_start: busy=%0b, required 1", busy0);
      end
      for (int k = 1; k < 52; k++) begin
         tick();
         if (busy0 !== 1'b1 || num0 !== 4'd0 || left0 !== 6'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL init_52_cycles: %0d bad cycles, required 0", bad);
      end
      tick();
      checks++;
      if (busy0 !== 1'b0 || left0 !== 6'd52 || num0 !== 4'd0) begin
         errors++;
         $display("FAIL init_done: busy=%0b left=%0d number=%0d, required 0 52 0",
                  busy0, left0, num0);
      end
   endtask

   task automatic test_single_pulses();
      int bad_zero = 0;
      for (int r = 1; r <= 13; r++) begin
         pip0 = 1'b1;
         tick();
         pip0 = 1'b0;
         checks++;
         if (num0 !== 4'(r)) begin
            errors++;
            $display("FAIL pulse_card: number=%0d, required %0d", num0, r);
         end
         tick();
         if (num0 !== 4'd0) bad_zero++;
         tick();
         if (num0 !== 4'd0) bad_zero++;
      end
      checks++;
      if (bad_zero != 0) begin
         errors++;
         $display("FAIL pulse_gap_zero: %0d non-zero gap cycles, required 0", bad_zero);
      end
      checks++;
      if (left0 !== 6'd39) begin
         errors++;
         $display("FAIL pulse_left: cards_left=%0d, required 39", left0);
      end
   endtask

   task automatic test_back_to_back();
      reset0();
      wait_ready0();
      pip0 = 1'b1;
      tick();
      checks++;
      if (num0 !== 4'd1) begin
         errors++;
         $display("FAIL b2b_first: number=%0d, required 1", num0);
      end
      tick();
      pip0 = 1'b0;
      checks++;
      if (num0 !== 4'd2) begin
         errors++;
         $display("FAIL b2b_second: number=%0d, required 2", num0);
      end
      tick();
      checks++;
      if (num0 !== 4'd0 || left0 !== 6'd50) begin
         errors++;
         $display("FAIL b2b_after: number=%0d left=%0d, required 0 50", num0, left0);
      end
   endtask

   task automatic test_deal_all();
      int bad = 0;
      reset0();
      wait_ready0();
      pip0 = 1'b1;
      for (int k = 0; k < 52; k++) begin
         tick();
         if (num0 !== 4'((k % 13) + 1)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL deal_all_order: %0d wrong cards, required 0", bad);
      end
      checks++;
      if (num0 !== 4'd13 || left0 !== 6'd0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL deal_all_last: number=%0d left=%0d busy=%0b, required 13 0 0",
                  num0, left0, busy0);
      end
      tick();
      checks++;
      if (busy0 !== 1'b1 || num0 !== 4'd0) begin
         errors++;
         $display("FAIL empty_to_init: busy=%0b number=%0d, required 1 0", busy0, num0);
      end
      bad = 0;
      for (int k = 1; k < 52; k++) begin
         tick();
         if (busy0 !== 1'b1 || num0 !== 4'd0 || left0 !== 6'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL refill_pip_ignored: %0d bad cycles, required 0", bad);
      end
      tick();
      pip0 = 1'b0;
      checks++;
      if (busy0 !== 1'b0 || left0 !== 6'd52 || num0 !== 4'd0) begin
         errors++;
         $display("FAIL refill_done: busy=%0b left=%0d number=%0d, required 0 52 0",
                  busy0, left0, num0);
      end
   endtask

   task automatic test_shuffle();
      int counts [16];
      int n2 = 0;
      int ordered = 1;
      int diff = 0;
      reset1_and_wait(ready_cycles);
      checks++;
      if (left1 !== 6'd52) begin
         errors++;
         $display("FAIL shuffle_left: cards_left=%0d, required 52", left1);
      end
      pip1 = 1'b1;
      for (int k = 0; k < 52; k++) begin
         tick();
         seq1[k] = num1;
      end
      pip1 = 1'b0;
      for (int r = 0; r < 16; r++) counts[r] = 0;
      for (int k = 0; k < 52; k++) begin
         counts[seq1[k]]++;
         if (seq1[k] !== 4'((k % 13) + 1)) ordered = 0;
      end
      for (int r = 1; r <= 13; r++) begin
         checks++;
         if (counts[r] != 4) begin
            errors++;
            $display("FAIL rank_count: rank %0d seen %0d times, required 4", r, counts[r]);
         end
      end
      checks++;
      if (ordered != 0) begin
         errors++;
         $display("FAIL shuffle_effect: deck came out ordered, required a permutation");
      end
      reset1_and_wait(n2);
      checks++;
      if (n2 != ready_cycles) begin
         errors++;
         $display("FAIL repeat_ready_time: %0d cycles, required %0d", n2, ready_cycles);
      end
      pip1 = 1'b1;
      for (int k = 0; k < 52; k++) begin
         tick();
         seq2[k] = num1;
      end
      pip1 = 1'b0;
      for (int k = 0; k < 52; k++) begin
         if (seq2[k] !== seq1[k]) diff++;
      end
      checks++;
      if (diff != 0) begin
         errors++;
         $display("FAIL repeat_sequence: %0d positions differ, required 0", diff);
      end
   endtask

   task automatic test_reshuffle_abort();
      int n = 0;
      while (busy1 && n < 5000) begin
         tick();
         n++;
      end
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reshuffle_ready_timeout: busy=%0b, required 0", busy1);
      end
      pip1  = 1'b1;
      resh1 = 1'b1;
      tick();
      pip1  = 1'b0;
      resh1 = 1'b0;
      checks++;
      if (num1 !== 4'd0 || busy1 !== 1'b1 || left1 !== 6'd0) begin
         errors++;
         $display("FAIL reshuffle_priority: number=%0d busy=%0b left=%0d, required 0 1 0",
                  num1, busy1, left1);
      end
      // 52 fill cycles then a few cycles into the (at least 51-cycle) shuffle
      for (int k = 0; k < 60; k++) tick();
      checks++;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL mid_shuffle_busy: busy=%0b, required 1", busy1);
      end
      #2;
      rst1_n = 1'b0;
      #1;
      checks++;
      if (num1 !== 4'd0 || busy1 !== 1'b1 || left1 !== 6'd0) begin
         errors++;
         $display("FAIL async_abort: number=%0d busy=%0b left=%0d, required 0 1 0",
                  num1, busy1, left1);
      end
      tick();
      rst1_n = 1'b1;
      n = 0;
      while (busy1 && n < 5000) begin
         tick();
         n++;
      end
      checks++;
      if (n != ready_cycles) begin
         errors++;
         $display("FAIL restart_ready_time: %0d cycles, required %0d", n, ready_cycles);
      end
      pip1 = 1'b1;
      tick();
      pip1 = 1'b0;
      checks++;
      if (num1 !== seq1[0]) begin
         errors++;
         $display("FAIL restart_first_card: number=%0d, required %0d", num1, seq1[0]);
      end
   endtask

   initial begin
      rst0_n = 1'b0;
      pip0   = 1'b0;
      resh0  = 1'b0;
      rst1_n = 1'b0;
      pip1   = 1'b0;
      resh1  = 1'b0;
      test_reset();
      test_single_pulses();
      test_back_to_back();
      test_deal_all();
      test_shuffle();
      test_reshuffle_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
